tacho_gate_ctrl: RTL and testbench
==================================

TACHO_GATE_CTRL -- requirements
Module: tacho_gate_ctrl

Interface
REQ-001 Parameter GATE_LEN, default 200, sets the gate window length in clk cycles; legal range is 1..65535.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port start, input, 1 bit: requests one measurement; sampled in IDLE and DONE only.
REQ-005 Port pulse, input, 1 bit: asynchronous rotation-sensor pulse train.
REQ-006 Port busy, output, 1 bit: high while the state is GATE.
REQ-007 Port ready, output, 1 bit: single-cycle strobe marking a new result on count/ovf.
REQ-008 Port count, output, 8 bits: latched pulse count of the last completed gate.
REQ-009 Port ovf, output, 1 bit: latched overflow flag of the last completed gate.

Function
REQ-010 pulse SHALL pass through a 2-flop synchronizer plus a third flop; edge = sync2 & ~sync3.
REQ-011 The FSM SHALL have states IDLE, GATE and DONE, using a 16-bit gate timer and an 8-bit accumulator acc.
REQ-012 IDLE with start=1 -> GATE; on that edge acc=0, internal ovf=0 and timer=GATE_LEN-1.
REQ-013 IDLE with start=0 -> IDLE.
REQ-014 GATE: each cycle with edge=1 SHALL increment acc; the timer decrements each cycle.
REQ-015 GATE with timer==0 -> DONE; an edge in that final cycle SHALL still be counted.
REQ-016 The window SHALL be exactly GATE_LEN cycles: start sampled at edge k gives GATE on cycles k+1..k+GATE_LEN.
REQ-017 DONE: count<=acc, ovf<=internal ovf, and ready=1 for that one cycle.
REQ-018 DONE with start=1 -> GATE, with the same initialisation as REQ-012 (back-to-back, period GATE_LEN+1 cycles).
REQ-019 DONE with start=0 -> IDLE.
REQ-020 start in GATE SHALL be ignored.
REQ-021 Edges arriving outside GATE SHALL be discarded.
REQ-022 count and ovf SHALL hold their value between DONE cycles.
REQ-023 busy and ready SHALL be driven directly from state registers (glitch-free).

Reset
REQ-024 rst=1 SHALL immediately force the state to IDLE.
REQ-025 rst=1 SHALL clear count=0, ovf=0, ready=0, busy=0, acc=0, timer=0 and all synchronizer flops.
REQ-026 rst asserted mid-GATE SHALL abort the measurement with no ready strobe; the prior result is lost (cleared).
REQ-027 After rst deasserts, the FSM SHALL stay in IDLE until start=1.

Configuration
REQ-028 Macro TACHO_SAT_EN defined: acc SHALL saturate at 255; an edge at acc==255 sets internal ovf=1 and acc stays 255.
REQ-029 Macro TACHO_SAT_EN undefined: acc SHALL wrap 255->0 (modulo 256); internal ovf is set at the first wrap and stays set until the next gate start.

Verification
REQ-030 GATE_LEN=16, pulse square wave of period 4 clk, one start pulse -> busy high 16 cycles, ready at cycle 17, count=4, ovf=0.
REQ-031 GATE_LEN=16, pulse held at 0 -> count=0, ovf=0, ready strobe exactly once.
REQ-032 GATE_LEN=1000, pulse toggling every clk (500 edges) -> TACHO_SAT_EN: count=255, ovf=1; without it: count=244, ovf=1.
REQ-033 GATE_LEN=16, start held high -> ready strobes every 17 cycles and busy is low only during the DONE cycles.
REQ-034 rst pulsed at cycle 8 of a 16-cycle gate -> state IDLE, count=0, no ready strobe; a new start then gives a normal result.
REQ-035 start pulsed during GATE, and pulse edges injected in IDLE -> no effect on the window length or on count.

Source files
------------

// File: rtl/tacho_gate_ctrl.sv
// Tachometer gate controller: counts synchronized pulse rising edges over a GATE_LEN-cycle window.
// Build option TACHO_SAT_EN: accumulator saturates at 255 instead of wrapping modulo 256.
module tacho_gate_ctrl #(
  parameter int unsigned GATE_LEN = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pulse,
  output logic       busy,
  output logic       ready,
  output logic [7:0] count,
  output logic       ovf
);

  typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;

  localparam logic [15:0] TIMER_INIT = 16'(GATE_LEN - 1);

  state_t      state;
  logic        sync1, sync2, sync3;
  logic        pulse_edge;
  logic [15:0] timer;
  logic [7:0]  acc;
  logic        acc_ovf;
  logic [7:0]  acc_nxt;
  logic        ovf_nxt;

  assign pulse_edge = sync2 & ~sync3;

  // Accumulator value including this cycle's edge; used both for the running
  // count and for the result latched on the final gate cycle.
  always_comb begin
    acc_nxt = acc;
    ovf_nxt = acc_ovf;
    if (pulse_edge) begin
      if (acc == 8'hFF) begin
        ovf_nxt = 1'b1;
`ifdef TACHO_SAT_EN
        acc_nxt = 8'hFF;
`else
        acc_nxt = 8'h00;
`endif
      end else begin
        acc_nxt = acc + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync3   <= 1'b0;
      timer   <= 16'd0;
      acc     <= 8'd0;
      acc_ovf <= 1'b0;
      busy    <= 1'b0;
      ready   <= 1'b0;
      count   <= 8'd0;
      ovf     <= 1'b0;
    end else begin
      sync1 <= pulse;
      sync2 <= sync1;
      sync3 <= sync2;
      ready <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= GATE;
            busy    <= 1'b1;
            acc     <= 8'd0;
            acc_ovf <= 1'b0;
            timer   <= TIMER_INIT;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        GATE: begin
          acc     <= acc_nxt;
          acc_ovf <= ovf_nxt;
          if (timer == 16'd0) begin
            // Result is published on entry to DONE so it is valid alongside ready.
            state <= DONE;
            busy  <= 1'b0;
            ready <= 1'b1;
            count <= acc_nxt;
            ovf   <= ovf_nxt;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tacho_gate_ctrl.sv
// Directed bench for tacho_gate_ctrl: a GATE_LEN=16 instance for window/corner cases, a GATE_LEN=1000 instance for overflow.
module tb_tacho_gate_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_s, pulse_s, busy_s, ready_s, ovf_s;
  logic [7:0] count_s;
  logic       start_b, pulse_b, busy_b, ready_b, ovf_b;
  logic [7:0] count_b;

  int n_cmp = 0;
  int n_bad = 0;
  int half_s = 0;
  int half_b = 0;
  int ph_s = 0;
  int ph_b = 0;

  always #5 clk = ~clk;

  tacho_gate_ctrl #(.GATE_LEN(16)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .pulse(pulse_s),
    .busy(busy_s), .ready(ready_s), .count(count_s), .ovf(ovf_s)
  );

  tacho_gate_ctrl #(.GATE_LEN(1000)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .pulse(pulse_b),
    .busy(busy_b), .ready(ready_b), .count(count_b), .ovf(ovf_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Free-running pulse trains; half == 0 holds the line low.
  initial begin
    pulse_s = 1'b0;
    forever begin
      tick();
      if (half_s == 0) begin
        pulse_s = 1'b0;
        ph_s = 0;
      end else begin
        ph_s++;
        if (ph_s >= half_s) begin
          ph_s = 0;
          pulse_s = ~pulse_s;
        end
      end
    end
  end

  initial begin
    pulse_b = 1'b0;
    forever begin
      tick();
      if (half_b == 0) begin
        pulse_b = 1'b0;
        ph_b = 0;
      end else begin
        ph_b++;
        if (ph_b >= half_b) begin
          ph_b = 0;
          pulse_b = ~pulse_b;
        end
      end
    end
  end

  // One start pulse on the small instance, then observe 40 cycles.
  // mid_start > 0 raises start again during that observed cycle.
  task automatic measure(input int mid_start, output int busy_n, output int ready_n,
                         output int ready_idx, output int cnt, output int ov);
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    busy_n = 0; ready_n = 0; ready_idx = 0; cnt = -1; ov = -1;
    for (int i = 1; i <= 40; i++) begin
      if (busy_s) busy_n++;
      if (ready_s) begin
        ready_n++;
        if (ready_idx == 0) ready_idx = i;
        cnt = int'(count_s);
        ov = int'(ovf_s);
      end
      start_s = (i == mid_start);
      tick();
    end
    start_s = 1'b0;
  endtask

  typedef struct {
    string name;
    int    half;
    int    exp_count;
    int    exp_ovf;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int bn, rn, ri, c, o, mis, last, nr, exp_big;

    vecs[0] = '{"sq4",   2, 4, 0};
    vecs[1] = '{"idle0", 0, 0, 0};
    vecs[2] = '{"sq2",   1, 8, 0};
    vecs[3] = '{"sq8",   4, 2, 0};
    vecs[4] = '{"sq16",  8, 1, 0};

    rst = 1'b1;
    start_s = 1'b0;
    start_b = 1'b0;
    repeat (3) tick();
    check("rst_busy",  int'(busy_s),  0);
    check("rst_ready", int'(ready_s), 0);
    check("rst_count", int'(count_s), 0);
    check("rst_ovf",   int'(ovf_s),   0);
    rst = 1'b0;
    half_s = 2;
    mis = 0;
    repeat (20) begin
      tick();
      if (busy_s || ready_s) mis++;
    end
    check("idle_hold_no_start", mis, 0);

    foreach (vecs[k]) begin
      half_s = vecs[k].half;
      repeat (20) tick();
      measure(0, bn, rn, ri, c, o);
      check({vecs[k].name, "_busy_cycles"}, bn, 16);
      check({vecs[k].name, "_ready_idx"},   ri, 17);
      check({vecs[k].name, "_ready_n"},     rn, 1);
      check({vecs[k].name, "_count"},       c,  vecs[k].exp_count);
      check({vecs[k].name, "_ovf"},         o,  vecs[k].exp_ovf);
      check({vecs[k].name, "_count_held"},  int'(count_s), vecs[k].exp_count);
    end

    // start raised mid-gate and on the final gate cycle is ignored
    half_s = 2;
    repeat (20) tick();
    measure(5, bn, rn, ri, c, o);
    check("mid5_busy_cycles", bn, 16);
    check("mid5_ready_n",     rn, 1);
    check("mid5_count",       c,  4);
    measure(16, bn, rn, ri, c, o);
    check("mid16_busy_cycles", bn, 16);
    check("mid16_ready_n",     rn, 1);
    check("mid16_count",       c,  4);

    // reset in the middle of a gate
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    repeat (7) tick();
    check("pre_rst_busy", int'(busy_s), 1);
    rst = 1'b1;
    #1;
    check("midrst_busy",  int'(busy_s),  0);
    check("midrst_count", int'(count_s), 0);
    check("midrst_ovf",   int'(ovf_s),   0);
    tick();
    rst = 1'b0;
    mis = 0;
    repeat (25) begin
      tick();
      if (busy_s || ready_s) mis++;
    end
    check("post_rst_idle", mis, 0);
    measure(0, bn, rn, ri, c, o);
    check("post_rst_ready_idx", ri, 17);
    check("post_rst_count",     c,  4);

    // start held high: back-to-back windows every 17 cycles
    start_s = 1'b1;
    tick();
    mis = 0; last = 0; nr = 0;
    for (int i = 1; i <= 60; i++) begin
      if (busy_s == ready_s) mis++;
      if (ready_s) begin
        nr++;
        check("b2b_period", i - last, 17);
        check("b2b_count", int'(count_s), 4);
        last = i;
      end
      tick();
    end
    start_s = 1'b0;
    check("b2b_ready_n", nr, 3);
    check("b2b_busy_vs_ready", mis, 0);
    repeat (25) tick();

    // 1000-cycle gate, pulse toggling every clock: 500 edges
`ifdef TACHO_SAT_EN
    exp_big = 255;
`else
    exp_big = 244;
`endif
    half_b = 1;
    repeat (10) tick();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    bn = 0; ri = 0; c = -1; o = -1;
    for (int i = 1; i <= 1100; i++) begin
      if (busy_b) bn++;
      if (ready_b && ri == 0) begin
        ri = i;
        c = int'(count_b);
        o = int'(ovf_b);
      end
      tick();
    end
    check("big_busy_cycles", bn, 1000);
    check("big_ready_idx",   ri, 1001);
    check("big_count",       c,  exp_big);
    check("big_ovf",         o,  1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
